// File: rtl/counter_bank_if.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | counter_bank_if : host, increment and overflow signals of bank  |
// | Revision: 1.0                                                   |
// +-----------------------------------------------------------------+
interface counter_bank_if #(
  parameter int NUM_CH = 3,
  parameter int XLEN   = 32,
  parameter int SEL_W  = 4
);
  logic [NUM_CH-1:0] inc;
  logic [NUM_CH-1:0] inhibit;
  logic [NUM_CH-1:0] ovf;
  logic [NUM_CH-1:0] ovf_clr;
  logic              wr_en;
  logic [SEL_W-1:0]  wr_sel;
  logic              wr_hi;
  logic [XLEN-1:0]   wr_data;
  logic              rd_en;
  logic [SEL_W-1:0]  rd_sel;
  logic              rd_hi;
  logic [XLEN-1:0]   rd_data;
  logic              rd_valid;

  modport master (
    output inc, inhibit, ovf_clr, wr_en, wr_sel, wr_hi, wr_data,
    output rd_en, rd_sel, rd_hi,
    input  rd_data, rd_valid, ovf
  );

  modport slave (
    input  inc, inhibit, ovf_clr, wr_en, wr_sel, wr_hi, wr_data,
    input  rd_en, rd_sel, rd_hi,
    output rd_data, rd_valid, ovf
  );
endinterface
`default_nettype wire

// File: rtl/counter_bank.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | counter_bank : NUM_CH wide counters with split-half host access |
// | Revision: 1.0                                                   |
// +-----------------------------------------------------------------+
module counter_bank #(
  parameter int NUM_CH    = 3,
  parameter int CNT_WIDTH = 64,
  parameter int XLEN      = 32,
  parameter int SEL_W     = 4
) (
  input  logic           clk,
  input  logic           resetn,
  counter_bank_if.slave  bus
);
  localparam int HI_W = CNT_WIDTH - XLEN;

  logic [CNT_WIDTH-1:0] w_cnt [NUM_CH];
  logic [NUM_CH-1:0]    w_ovf;
  logic [XLEN-1:0]      w_rd_val;
  logic [XLEN-1:0]      r_rd_data;
  logic                 r_rd_valid;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_ovf;
    logic                 w_wr_hit;
    logic                 w_inc;
    logic                 w_wrap;

    // A host write to this channel swallows any same-cycle increment.
    assign w_wr_hit = bus.wr_en && (bus.wr_sel == SEL_W'(i));
    assign w_inc    = bus.inc[i] && !bus.inhibit[i] && !w_wr_hit;
    assign w_wrap   = w_inc && (&r_cnt);

    always_ff @(posedge clk) begin
      if (!resetn) begin
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else begin
        if (w_wr_hit) begin
          if (bus.wr_hi)
            r_cnt[CNT_WIDTH-1:XLEN] <= bus.wr_data[HI_W-1:0];
          else
            r_cnt[XLEN-1:0] <= bus.wr_data;
        end else if (w_inc) begin
          r_cnt <= r_cnt + CNT_WIDTH'(1);
        end

        if (w_wrap)
          r_ovf <= 1'b1;
        else if (bus.ovf_clr[i])
          r_ovf <= 1'b0;
      end
    end

    assign w_cnt[i] = r_cnt;
    assign w_ovf[i] = r_ovf;
  end

  always_comb begin
    w_rd_val = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (bus.rd_sel == SEL_W'(k)) begin
        if (bus.rd_hi)
          w_rd_val = XLEN'(w_cnt[k][CNT_WIDTH-1:XLEN]);
        else
          w_rd_val = w_cnt[k][XLEN-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= bus.rd_en;
      if (bus.rd_en)
        r_rd_data <= w_rd_val;
    end
  end

  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_rd_valid;
  assign bus.ovf      = w_ovf;
endmodule
`default_nettype wire

// File: tb/tb_counter_bank.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_counter_bank : directed self-checking bench for counter_bank |
// | Revision: 1.0                                                   |
// +-----------------------------------------------------------------+
module tb_counter_bank;
  logic clk;
  logic resetn;
  int   checks;
  int   failures;

  counter_bank_if #(.NUM_CH(3), .XLEN(32), .SEL_W(4)) bus ();

  counter_bank #(
    .NUM_CH(3), .CNT_WIDTH(64), .XLEN(32), .SEL_W(4)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] sel, input logic hi, input logic [31:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_sel  = sel;
    bus.wr_hi   = hi;
    bus.wr_data = data;
    step();
    bus.wr_en   = 1'b0;
  endtask

  task automatic rd(input logic [3:0] sel, input logic hi, input logic [31:0] exp, input string tag);
    bus.rd_en  = 1'b1;
    bus.rd_sel = sel;
    bus.rd_hi  = hi;
    step();
    bus.rd_en  = 1'b0;
    chk({tag, "_valid"}, 64'(bus.rd_valid), 64'd1);
    chk(tag, 64'(bus.rd_data), 64'(exp));
  endtask

  initial begin
    clk         = 1'b0;
    resetn      = 1'b0;
    checks      = 0;
    failures    = 0;
    bus.inc     = '0;
    bus.inhibit = '0;
    bus.ovf_clr = '0;
    bus.wr_en   = 1'b0;
    bus.wr_sel  = '0;
    bus.wr_hi   = 1'b0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;
    bus.rd_sel  = '0;
    bus.rd_hi   = 1'b0;

    step();
    step();
    chk("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    chk("rst_rd_data",  64'(bus.rd_data),  64'd0);
    chk("rst_ovf",      64'(bus.ovf),      64'd0);
    resetn = 1'b1;

    // Five increments on channel 0
    bus.inc = 3'b001;
    repeat (5) step();
    bus.inc = 3'b000;
    rd(4'd0, 1'b0, 32'd5, "ch0_lo_5");
    rd(4'd1, 1'b0, 32'd0, "ch1_lo_0");
    rd(4'd2, 1'b0, 32'd0, "ch2_lo_0");

    // Back-to-back reads, then idle holds data
    bus.rd_en = 1'b1; bus.rd_sel = 4'd0; bus.rd_hi = 1'b1;
    step();
    chk("b2b_hi_valid", 64'(bus.rd_valid), 64'd1);
    chk("b2b_hi_data",  64'(bus.rd_data),  64'd0);
    bus.rd_hi = 1'b0;
    step();
    chk("b2b_lo_valid", 64'(bus.rd_valid), 64'd1);
    chk("b2b_lo_data",  64'(bus.rd_data),  64'd5);
    bus.rd_en = 1'b0;
    step();
    chk("idle_valid", 64'(bus.rd_valid), 64'd0);
    chk("idle_hold",  64'(bus.rd_data),  64'd5);

    // Carry from low half into high half
    wr(4'd1, 1'b0, 32'hFFFF_FFFF);
    wr(4'd1, 1'b1, 32'h0000_0000);
    bus.inc = 3'b010;
    step();
    bus.inc = 3'b000;
    rd(4'd1, 1'b0, 32'd0, "ch1_carry_lo");
    rd(4'd1, 1'b1, 32'd1, "ch1_carry_hi");
    chk("ch1_no_ovf", 64'(bus.ovf), 64'd0);

    // Full wrap of channel 2
    wr(4'd2, 1'b0, 32'hFFFF_FFFF);
    wr(4'd2, 1'b1, 32'hFFFF_FFFF);
    bus.inc = 3'b100;
    step();
    bus.inc = 3'b000;
    chk("ch2_ovf_set", 64'(bus.ovf), 64'd4);
    rd(4'd2, 1'b0, 32'd0, "ch2_wrap_lo");
    rd(4'd2, 1'b1, 32'd0, "ch2_wrap_hi");
    bus.ovf_clr = 3'b100;
    step();
    bus.ovf_clr = 3'b000;
    chk("ch2_ovf_clr", 64'(bus.ovf), 64'd0);
    wr(4'd2, 1'b0, 32'hFFFF_FFFF);
    wr(4'd2, 1'b1, 32'hFFFF_FFFF);
    bus.inc = 3'b100; bus.ovf_clr = 3'b100;
    step();
    bus.inc = 3'b000; bus.ovf_clr = 3'b000;
    chk("ch2_set_wins", 64'(bus.ovf), 64'd4);

    // Write beats increment on the same channel
    bus.inc = 3'b001;
    wr(4'd0, 1'b0, 32'h10);
    bus.inc = 3'b000;
    rd(4'd0, 1'b0, 32'h10, "wr_prio_lo");
    rd(4'd0, 1'b1, 32'h0,  "wr_prio_hi");

    // Out-of-range write is ignored
    wr(4'd3, 1'b0, 32'hDEAD_BEEF);
    rd(4'd0, 1'b0, 32'h10, "oor_wr_ch0");
    rd(4'd2, 1'b0, 32'h0,  "oor_wr_ch2");

    // Inhibit blocks increments; out-of-range read returns zero
    bus.inhibit = 3'b001; bus.inc = 3'b001;
    repeat (10) step();
    bus.inhibit = 3'b000; bus.inc = 3'b000;
    rd(4'd0, 1'b0, 32'h10, "inhibit_ch0");
    rd(4'd7, 1'b0, 32'h0,  "rd_sel7");

    // Read returns the pre-edge value while the channel increments
    bus.inc = 3'b001;
    rd(4'd0, 1'b0, 32'h10, "rd_pre_inc");
    bus.inc = 3'b000;
    rd(4'd0, 1'b0, 32'h11, "rd_post_inc");

    // Bring all channels to 100, then reset in the middle of a read
    wr(4'd0, 1'b0, 32'd0);
    wr(4'd1, 1'b1, 32'd0);
    wr(4'd2, 1'b0, 32'd0);
    wr(4'd2, 1'b1, 32'd0);
    bus.inc = 3'b111;
    repeat (100) step();
    bus.inc = 3'b000;
    rd(4'd0, 1'b0, 32'd100, "ch0_100");
    rd(4'd1, 1'b0, 32'd100, "ch1_100");
    rd(4'd2, 1'b0, 32'd100, "ch2_100");
    chk("pre_rst_ovf", 64'(bus.ovf), 64'd4);
    bus.rd_en = 1'b1; bus.rd_sel = 4'd1; bus.rd_hi = 1'b0;
    bus.inc = 3'b111; bus.ovf_clr = 3'b000;
    resetn = 1'b0;
    step();
    chk("midrst_valid", 64'(bus.rd_valid), 64'd0);
    chk("midrst_data",  64'(bus.rd_data),  64'd0);
    chk("midrst_ovf",   64'(bus.ovf),      64'd0);
    resetn = 1'b1;
    bus.rd_en = 1'b0;
    bus.inc = 3'b000;
    rd(4'd0, 1'b0, 32'd0, "post_rst_ch0");
    rd(4'd1, 1'b0, 32'd0, "post_rst_ch1");
    rd(4'd2, 1'b0, 32'd0, "post_rst_ch2");
    bus.inc = 3'b001;
    step();
    bus.inc = 3'b000;
    rd(4'd0, 1'b0, 32'd1, "resume_ch0");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
